// File: rtl/mult_accumulator.sv
// Sums N_TERMS unsigned 4x4 products into an ACC_W-bit result; SAT_EN selects clamp instead of wrap on overflow.
// Latency: result valid one edge after the last operand is accepted (the product register adds one stage).
// Backpressure: in_ready drops once the group is complete; the result is held until out_ready.

module wallace_tree (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] r0, r1, r2, r3;
    logic [7:0] s1, c1, s2, c2;

    always_comb begin
        r0 = {4'b0, a & {4{b[0]}}};
        r1 = {3'b0, a & {4{b[1]}}, 1'b0};
        r2 = {2'b0, a & {4{b[2]}}, 2'b0};
        r3 = {1'b0, a & {4{b[3]}}, 3'b0};
        // Two levels of 3:2 compression, then one carry-propagate add.
        s1 = r0 ^ r1 ^ r2;
        c1 = (r0 & r1) | (r0 & r2) | (r1 & r2);
        s2 = s1 ^ {c1[6:0], 1'b0} ^ r3;
        c2 = (s1 & {c1[6:0], 1'b0}) | (s1 & r3) | ({c1[6:0], 1'b0} & r3);
        p  = s2 + {c2[6:0], 1'b0};
    end
endmodule

module mult_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N_TERMS);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             prod_v_q, prod_v_d;
    logic [7:0]       prod_q, prod_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic             out_valid_q, out_valid_d;
    logic             out_ovf_q, out_ovf_d;

    logic [7:0]       prod_w;
    logic             in_fire;
    logic             last_prod;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   sum_w;
    logic [ACC_W-1:0] acc_next;

    wallace_tree u_mul (
        .a (in_a),
        .b (in_b),
        .p (prod_w)
    );

    assign in_ready  = (in_cnt_q < N_CNT) && !out_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign last_prod = prod_v_q && (acc_cnt_q == (N_CNT - 8'd1));
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_ovf   = out_ovf_q;

    // The first product of a group loads rather than adds, so no clear of acc is needed.
    assign acc_base = (acc_cnt_q == '0) ? '0 : acc_q;
    assign sum_w    = {1'b0, acc_base} + (ACC_W+1)'(prod_q);
`ifdef SAT_EN
    assign acc_next = sum_w[ACC_W] ? ACC_MAX : sum_w[ACC_W-1:0];
`else
    assign acc_next = sum_w[ACC_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        prod_v_d    = 1'b0;
        prod_d      = prod_q;
        acc_d       = acc_q;
        out_acc_d   = out_acc_q;
        out_valid_d = out_valid_q;
        out_ovf_d   = out_ovf_q;

        if (in_fire) begin
            prod_d   = prod_w;
            prod_v_d = 1'b1;
            in_cnt_d = in_cnt_q + 8'd1;
        end

        if (prod_v_q) begin
            acc_d     = acc_next;
            acc_cnt_d = acc_cnt_q + 8'd1;
            if (sum_w[ACC_W]) begin
                out_ovf_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (last_prod) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_acc_d   = acc_next;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_cnt_d    = '0;
                    acc_cnt_d   = '0;
                    out_ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over every other event on the same edge.
        if (clear) begin
            state_d     = IDLE;
            in_cnt_d    = '0;
            acc_cnt_d   = '0;
            prod_v_d    = 1'b0;
            out_valid_d = 1'b0;
            out_ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_cnt_q    <= '0;
            acc_cnt_q   <= '0;
            prod_v_q    <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            out_acc_q   <= '0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            prod_v_q    <= prod_v_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            out_acc_q   <= out_acc_d;
            out_valid_q <= out_valid_d;
            out_ovf_q   <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_mult_accumulator.sv
// Three configurations (4/16, 8/10, 1/16) share one stimulus stream and are checked against a group-level model.
module tb_mult_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic out_ready = 1'b0;

    logic rdy0, rdy1, rdy2, vld0, vld1, vld2, ovf0, ovf1, ovf2;
    logic [15:0] acc0, acc2;
    logic [9:0]  acc1;
    logic [2:0]  rdy_a, vld_a, ovf_a;
    logic [15:0] accw [3];

    int n_checks = 0;
    int n_fail = 0;

    int     m_cnt  [3];
    bit     m_fly  [3];
    int     m_fly_p[3];
    longint m_sum  [3];
    bit     m_ov   [3];
    longint m_oacc [3];
    bit     m_oovf [3];
    bit     md_ok;
    longint md_mx;

    always #5 clk = ~clk;

    mult_accumulator #(.N_TERMS(4), .ACC_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy0),
        .in_a(in_a), .in_b(in_b), .out_valid(vld0), .out_ready(out_ready),
        .out_acc(acc0), .out_ovf(ovf0));
    mult_accumulator #(.N_TERMS(8), .ACC_W(10)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy1),
        .in_a(in_a), .in_b(in_b), .out_valid(vld1), .out_ready(out_ready),
        .out_acc(acc1), .out_ovf(ovf1));
    mult_accumulator #(.N_TERMS(1), .ACC_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy2),
        .in_a(in_a), .in_b(in_b), .out_valid(vld2), .out_ready(out_ready),
        .out_acc(acc2), .out_ovf(ovf2));

    assign rdy_a = {rdy2, rdy1, rdy0};
    assign vld_a = {vld2, vld1, vld0};
    assign ovf_a = {ovf2, ovf1, ovf0};
    always_comb begin
        accw[0] = acc0;
        accw[1] = {6'd0, acc1};
        accw[2] = acc2;
    end

    function automatic int nt(input int i);
        return (i == 0) ? 4 : (i == 1) ? 8 : 1;
    endfunction

    function automatic int aw(input int i);
        return (i == 1) ? 10 : 16;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Group-level model: a product lands one edge after it is accepted; the group
    // result is the exact sum of N products, wrapped or clamped to ACC_W bits.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0; m_fly[i] = 0; m_fly_p[i] = 0; m_sum[i] = 0;
                m_ov[i] = 0; m_oacc[i] = 0; m_oovf[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                md_mx = (longint'(1) << aw(i)) - 1;
                md_ok = in_valid && (m_cnt[i] < nt(i)) && !m_ov[i];
                if (clear) begin
                    m_cnt[i] = 0; m_fly[i] = 0; m_sum[i] = 0; m_ov[i] = 0;
                end else begin
                    if (m_ov[i] && out_ready) begin
                        m_ov[i] = 0; m_cnt[i] = 0; m_sum[i] = 0;
                    end
                    if (m_fly[i]) begin
                        m_sum[i] += m_fly_p[i];
                        if (m_cnt[i] == nt(i)) begin
                            m_ov[i] = 1;
`ifdef SAT_EN
                            m_oacc[i] = (m_sum[i] > md_mx) ? md_mx : m_sum[i];
`else
                            m_oacc[i] = m_sum[i] % (md_mx + 1);
`endif
                            m_oovf[i] = (m_sum[i] > md_mx);
                        end
                    end
                    m_fly[i] = md_ok;
                    m_fly_p[i] = int'(in_a) * int'(in_b);
                    if (md_ok) m_cnt[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                chk($sformatf("rst_vld%0d", i), vld_a[i], 0);
                chk($sformatf("rst_acc%0d", i), accw[i], 0);
                chk($sformatf("rst_ovf%0d", i), ovf_a[i], 0);
            end else begin
                chk($sformatf("in_ready%0d", i), rdy_a[i], (m_cnt[i] < nt(i)) && !m_ov[i]);
                chk($sformatf("out_valid%0d", i), vld_a[i], m_ov[i]);
                if (m_ov[i]) begin
                    chk($sformatf("out_acc%0d", i), accw[i], m_oacc[i]);
                    chk($sformatf("out_ovf%0d", i), ovf_a[i], m_oovf[i]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_clear();
        in_valid = 0; clear = 1;
        tick();
        clear = 0;
    endtask

    task automatic drive(input int a, input int b);
        in_valid = 1; in_a = 4'(a); in_b = 4'(b);
    endtask

    initial begin
        // Reset state
        #3;
        chk("reset_vld", vld0, 0);
        chk("reset_acc", acc0, 0);
        chk("reset_ovf", ovf0, 0);
        repeat (2) tick();
        rst_n = 1;
        #1;
        chk("post_reset_rdy", rdy0, 1);
        chk("post_reset_vld", vld0, 0);

        // Back-to-back group, four distinct pairs
        out_ready = 1;
        do_clear();
        drive(2, 4); tick();
        drive(7, 7); tick();
        drive(1, 12); tick();
        drive(3, 6); tick();
        in_valid = 0;
        chk("t2_vld_early", vld0, 0);
        tick();
        chk("t2_vld", vld0, 1);
        chk("t2_acc", acc0, 87);
        chk("t2_ovf", ovf0, 0);
        tick();
        chk("t2_pulse", vld0, 0);

        // Reset in the middle of a group
        drive(5, 5); tick(); tick();
        in_valid = 0;
        rst_n = 0;
        #1;
        chk("midrst_acc", acc0, 0);
        chk("midrst_vld", vld0, 0);
        tick();
        rst_n = 1;
        #1;
        chk("midrst_rdy", rdy0, 1);

        // Gapped operands with a stalled consumer
        do_clear();
        out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            drive(15, 15); tick();
            in_valid = 0;
            repeat (3) tick();
        end
        chk("t3_vld", vld0, 1);
        chk("t3_acc", acc0, 900);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_hold_acc", acc0, 900);
            chk("t3_hold_rdy", rdy0, 0);
        end
        out_ready = 1;
        tick();
        chk("t3_vld_done", vld0, 0);
        chk("t3_rdy_back", rdy0, 1);

        // clear coincides with the third accept
        do_clear();
        drive(2, 3); tick();
        drive(2, 3); tick();
        drive(2, 3); clear = 1; tick();
        clear = 0; in_valid = 0;
        chk("t5_rdy", rdy0, 1);
        chk("t5_vld", vld0, 0);
        drive(1, 1); repeat (4) tick();
        in_valid = 0;
        tick();
        chk("t5_vld2", vld0, 1);
        chk("t5_acc", acc0, 4);

        // Overflow on the 8-term, 10-bit instance
        do_clear();
        drive(15, 15); repeat (8) tick();
        in_valid = 0;
        tick();
        chk("t4_vld", vld1, 1);
`ifdef SAT_EN
        chk("t4_acc", acc1, 1023);
`else
        chk("t4_acc", acc1, 776);
`endif
        chk("t4_ovf", ovf1, 1);

        // Single-term instance
        do_clear();
        out_ready = 0;
        drive(13, 4); tick();
        in_valid = 0;
        chk("t6_vld_early", vld2, 0);
        tick();
        chk("t6_vld", vld2, 1);
        chk("t6_acc", acc2, 52);
        chk("t6_rdy", rdy2, 0);
        drive(5, 5); tick();
        chk("t6_rdy_hold", rdy2, 0);
        chk("t6_acc_hold", acc2, 52);
        out_ready = 1; tick();
        chk("t6_vld_done", vld2, 0);
        tick(); tick();
        in_valid = 0;
        chk("t6_acc2", acc2, 25);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(9) < 7);
            if ($urandom_range(3) == 0) begin
                in_a = 4'd15; in_b = 4'd15;
            end else begin
                in_a = 4'($urandom); in_b = 4'($urandom);
            end
            out_ready = ($urandom_range(9) < 6);
            clear = ($urandom_range(99) == 0);
            rst_n = !(c == 1500 || c == 1501);
            tick();
        end
        in_valid = 0; clear = 0; rst_n = 1; out_ready = 1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
